// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver feeding command bytes to the motor controller.
// Optional command filter: define UART_CMD_FILTER_EN to accept only 'A'/'B'.
module uart_cmd_rx #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dato,
    output logic       dato_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state;
    state_t state_next;

    logic          sync1;
    logic          synced;
    logic          delayed;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_done;
    logic          stop_done;
    logic          restart_cnt;
    logic          accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            synced  <= 1'b1;
            delayed <= 1'b1;
        end else begin
            sync1   <= rx;
            synced  <= sync1;
            delayed <= synced;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bit_done   = 1'b0;
        stop_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (delayed && !synced) begin
                    state_next = START;
                end
            end
            START: begin
                // A high sample mid start bit is a glitch, not a frame
                if (clk_cnt == CNT_HALF) begin
                    state_next = synced ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == CNT_FULL) begin
                    bit_done = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (clk_cnt == CNT_FULL) begin
                    stop_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        restart_cnt = (state_next != state) || bit_done;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
        end else begin
            if (restart_cnt || state == IDLE) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + CW'(1);
            end
            if (state == START) begin
                bit_idx <= 3'd0;
            end else if (bit_done) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (bit_done) begin
                shreg <= {synced, shreg[7:1]};
            end
        end
    end

`ifdef UART_CMD_FILTER_EN
    logic is_cmd;
    logic dropped;

    assign is_cmd = (shreg == 8'd65) || (shreg == 8'd66);
    assign accept = stop_done && synced && is_cmd;

    always_ff @(posedge clk) begin
        if (rst) begin
            dropped <= 1'b0;
        end else begin
            dropped <= stop_done && synced && !is_cmd;
        end
    end
`else
    assign accept = stop_done && synced;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            dato       <= 8'd0;
            dato_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dato_valid <= accept;
            frame_err  <= stop_done && !synced;
            if (accept) begin
                dato <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx at 16 clocks per bit.
// Frame-level reference model: expected byte, strobe and error counts.
module tb_uart_cmd_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] dato;
    logic       dato_valid;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_cmd_rx #(
        .CLK_HZ(160),
        .BAUD  (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .dato      (dato),
        .dato_valid(dato_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;

    int         v_cnt    = 0;
    int         f_cnt    = 0;
    int         both_cnt = 0;
    int         long_v   = 0;
    int         long_f   = 0;
    int         spur     = 0;
    int         drop_cnt = 0;
    logic [7:0] v_last   = 8'd0;
    logic       r_s      = 1'b0;
    logic       pv       = 1'b0;
    logic       pf       = 1'b0;
    logic [7:0] pd       = 8'd0;

    int         exp_v    = 0;
    int         exp_f    = 0;
    int         exp_drop = 0;
    logic [7:0] exp_dato = 8'd0;

    // Observe outputs 1 time unit after each rising edge
    always begin
        @(posedge clk);
        r_s = rst;
        #1;
        if (dato_valid) begin
            v_cnt++;
            v_last = dato;
        end
        if (frame_err) f_cnt++;
        if (dato_valid && frame_err) both_cnt++;
        if (dato_valid && pv) long_v++;
        if (frame_err && pf) long_f++;
        if (!r_s && !dato_valid && dato !== pd) spur++;
`ifdef UART_CMD_FILTER_EN
        if (dut.dropped) drop_cnt++;
`endif
        pv = dato_valid;
        pf = frame_err;
        pd = dato;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit accepts(input logic [7:0] b);
`ifdef UART_CMD_FILTER_EN
        return (b == 8'd65) || (b == 8'd66);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            exp_f++;
        end else if (accepts(b)) begin
            exp_v++;
            exp_dato = b;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_valid_cnt"}, v_cnt, exp_v);
        chk({tag, "_ferr_cnt"}, f_cnt, exp_f);
        chk({tag, "_dato"}, int'(dato), int'(exp_dato));
        chk({tag, "_drop_cnt"}, drop_cnt, exp_drop);
    endtask

    // Called on a falling edge; cut>0 stops after that many bit clocks
    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input bit chk_busy, input int cut);
        logic [9:0] bits;
        int         n;
        bits = {stop_ok, b, 1'b0};
        n    = 0;
        for (int k = 0; k < 10; k++) begin
            rx = bits[k];
            for (int i = 0; i < CPB; i++) begin
                @(negedge clk);
                n++;
                if (cut > 0 && n == cut) return;
                if (chk_busy && k == 0 && i == 1) chk("busy_pre", int'(busy), 0);
                if (chk_busy && k == 0 && i == 2) chk("busy_rise", int'(busy), 1);
                if (chk_busy && k == 9 && i == 9) begin
                    chk("busy_before_strobe", int'(busy), 1);
                    chk("valid_before_strobe", int'(dato_valid), 0);
                end
                if (chk_busy && k == 9 && i == 10) begin
                    chk("busy_at_strobe", int'(busy), 0);
                    chk("valid_at_strobe", int'(dato_valid), 1);
                    chk("dato_at_strobe", int'(dato), int'(b));
                end
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        int         gap;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dato", int'(dato), 0);
        chk("rst_valid", int'(dato_valid), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_dato", int'(dato), 0);
        chk("idle_busy", int'(busy), 0);
        chk_all("idle");

        send_frame(8'h41, 1'b1, 1'b1, 0);
        model_frame(8'h41, 1'b1);
        repeat (4) @(negedge clk);
        chk_all("single");
        chk("single_last", int'(v_last), 65);

        send_frame(8'h42, 1'b1, 1'b0, 0);
        model_frame(8'h42, 1'b1);
        chk("b2b_first", int'(dato), 66);
        send_frame(8'h55, 1'b1, 1'b0, 0);
        model_frame(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        chk_all("b2b");

        rx = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 4) rx = 1'b1;
            if (i == 10) chk("glitch_busy_hold", int'(busy), 1);
            if (i == 11) chk("glitch_busy_drop", int'(busy), 0);
        end
        repeat (20) @(negedge clk);
        chk_all("glitch");

        send_frame(8'h41, 1'b0, 1'b0, 0);
        model_frame(8'h41, 1'b0);
        rx = 1'b1;
        chk_all("ferr");
        repeat (3) @(negedge clk);
        send_frame(8'h42, 1'b1, 1'b0, 0);
        model_frame(8'h42, 1'b1);
        repeat (4) @(negedge clk);
        chk_all("after_ferr");

        send_frame(8'h41, 1'b1, 1'b0, 5 * CPB + 8);
        chk("midrst_busy_pre", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_dato", int'(dato), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(dato_valid), 0);
        rst      = 1'b0;
        rx       = 1'b1;
        exp_dato = 8'd0;
        repeat (5) @(negedge clk);
        chk_all("midrst_idle");
        send_frame(8'h42, 1'b1, 1'b0, 0);
        model_frame(8'h42, 1'b1);
        repeat (4) @(negedge clk);
        chk_all("midrst_recover");

        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            if (n % 3 == 0) b = (n % 2 == 1) ? 8'd65 : 8'd66;
            ok  = ($urandom_range(0, 4) != 0);
            gap = ok ? $urandom_range(0, 20) : $urandom_range(3, 20);
            send_frame(b, ok, 1'b0, 0);
            model_frame(b, ok);
            chk_all("rand");
            rx = 1'b1;
            repeat (gap) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("both_strobes", both_cnt, 0);
        chk("valid_width", long_v, 0);
        chk("ferr_width", long_f, 0);
        chk("dato_stray_change", spur, 0);
        chk_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
